// File: rtl/pkg_1553.sv
// rtl/pkg_1553.sv - shared constants and types for the 1553 word receiver
// Purpose: line-level encoding, decode FSM states, sync types and word length
//          shared by sync_detect_1553 and rx_decoder_1553.
// Ports:   none (package).
`timescale 1ns/1ps
package pkg_1553;

  // Line level is packed as {hi, lo}; the mapping never produces 2'b11.
  localparam logic [1:0] LVL_IDLE = 2'b00;
  localparam logic [1:0] LVL_LO   = 2'b01;
  localparam logic [1:0] LVL_HI   = 2'b10;

  localparam logic SYNC_DW  = 1'b0;
  localparam logic SYNC_CSW = 1'b1;

  // 16 data bits plus one parity bit
  localparam int WORD_BITS = 17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic [1:0] line_level(input logic p, input logic n);
    return {p & ~n, ~p & n};
  endfunction

endpackage

// File: rtl/sync_detect_1553.sv
// rtl/sync_detect_1553.sv - input synchroniser, line-level history and sync pattern match
// Purpose: brings rx_p/rx_n into clk, keeps the last 3*SPB line levels and
//          flags the first cycle a command/status or data sync is seen.
// Ports:   clk, rst_n       - clock, async active-low reset
//          rx_p, rx_n       - asynchronous transceiver outputs
//          lvl              - newest synchronised line level ({hi, lo})
//          sync_csw/sync_dw - one-cycle pulse on the first cycle of a sync match
`timescale 1ns/1ps
module sync_detect_1553
  import pkg_1553::*;
#(
  parameter int SPB      = 8,
  parameter int SYNC_TOL = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_p,
  input  logic       rx_n,
  output logic [1:0] lvl,
  output logic       sync_csw,
  output logic       sync_dw
);

  localparam int SR_LEN = 3 * SPB;
  localparam int HALF   = SR_LEN / 2;

  logic              p_meta_q, p_meta_d, p_sync_q, p_sync_d;
  logic              n_meta_q, n_meta_d, n_sync_q, n_sync_d;
  logic [SR_LEN-1:0] hi_sr_q, hi_sr_d, lo_sr_q, lo_sr_d;
  logic              csw_prev_q, csw_prev_d, dw_prev_q, dw_prev_d;
  logic [1:0]        lvl_now;
  logic              csw_match, dw_match;

  // Bit 0 of the history is the newest sample; the older half (indices
  // HALF..SR_LEN-1) is the first half of the sync. Samples within SYNC_TOL
  // of the sync's start, middle and end are don't-care.
  always_comb begin
    p_meta_d  = rx_p;
    p_sync_d  = p_meta_q;
    n_meta_d  = rx_n;
    n_sync_d  = n_meta_q;
    lvl_now   = line_level(p_sync_q, n_sync_q);
    hi_sr_d   = {hi_sr_q[SR_LEN-2:0], lvl_now[1]};
    lo_sr_d   = {lo_sr_q[SR_LEN-2:0], lvl_now[0]};
    csw_match = 1'b1;
    dw_match  = 1'b1;
    for (int i = 0; i < SR_LEN; i++) begin
      if (i >= SYNC_TOL && i < SR_LEN - SYNC_TOL &&
          (i < HALF - SYNC_TOL || i >= HALF + SYNC_TOL)) begin
        if (i >= HALF) begin
          csw_match = csw_match & hi_sr_q[i];
          dw_match  = dw_match & lo_sr_q[i];
        end else begin
          csw_match = csw_match & lo_sr_q[i];
          dw_match  = dw_match & hi_sr_q[i];
        end
      end
    end
    csw_prev_d = csw_match;
    dw_prev_d  = dw_match;
  end

  // A clean sync matches for several consecutive cycles; report only the first.
  assign sync_csw = csw_match & ~csw_prev_q;
  assign sync_dw  = dw_match & ~dw_prev_q;
  assign lvl      = {hi_sr_q[0], lo_sr_q[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_meta_q   <= 1'b0;
      p_sync_q   <= 1'b0;
      n_meta_q   <= 1'b0;
      n_sync_q   <= 1'b0;
      hi_sr_q    <= '0;
      lo_sr_q    <= '0;
      csw_prev_q <= 1'b0;
      dw_prev_q  <= 1'b0;
    end else begin
      p_meta_q   <= p_meta_d;
      p_sync_q   <= p_sync_d;
      n_meta_q   <= n_meta_d;
      n_sync_q   <= n_sync_d;
      hi_sr_q    <= hi_sr_d;
      lo_sr_q    <= lo_sr_d;
      csw_prev_q <= csw_prev_d;
      dw_prev_q  <= dw_prev_d;
    end
  end

endmodule

// File: rtl/rx_decoder_1553.sv
// rtl/rx_decoder_1553.sv - MIL-STD-1553 Manchester-II word receiver, one channel
// Purpose: after a sync, samples each half of 17 bit times, decodes data and
//          odd parity, and presents one word per word time.
// Ports:   clk, rst_n          - sample clock (SPB MHz), async active-low reset
//          rx_p, rx_n          - asynchronous transceiver outputs
//          rx_dword            - decoded word, MSB first received
//          rx_csw / rx_dw      - sync type of the last good word
//          rx_dval             - one-cycle pulse, word outputs valid
//          rx_perr             - odd-parity failure, qualified by rx_dval
//          rx_merr             - one-cycle pulse, Manchester/idle error
//          rx_busy             - word reception in progress
`timescale 1ns/1ps
module rx_decoder_1553
  import pkg_1553::*;
#(
  parameter int SPB      = 8,
  parameter int SYNC_TOL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_p,
  input  logic        rx_n,
  output logic [15:0] rx_dword,
  output logic        rx_csw,
  output logic        rx_dw,
  output logic        rx_dval,
  output logic        rx_perr,
  output logic        rx_merr,
  output logic        rx_busy
);

  localparam int               CNT_W     = $clog2(WORD_BITS * SPB);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WORD_BITS * SPB - 1);
  localparam int               PH_FIRST  = SPB / 4;
  localparam int               PH_SECOND = SPB / 2 + SPB / 4;

  logic [1:0] lvl;
  logic       sync_csw, sync_dw;

  sync_detect_1553 #(
    .SPB      (SPB),
    .SYNC_TOL (SYNC_TOL)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_p     (rx_p),
    .rx_n     (rx_n),
    .lvl      (lvl),
    .sync_csw (sync_csw),
    .sync_dw  (sync_dw)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;   // first half of current bit was HI
  logic [15:0]      data_q, data_d;
  logic             par_q, par_d;
  logic             type_q, type_d;
  logic [15:0]      dword_q, dword_d;
  logic             csw_q, csw_d, dw_q, dw_d, perr_q, perr_d;
  logic             dval_q, dval_d, merr_q, merr_d, busy_q, busy_d;
  int               bit_idx, phase;
  logic             bad;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    data_d  = data_q;
    par_d   = par_q;
    type_d  = type_q;
    dword_d = dword_q;
    csw_d   = csw_q;
    dw_d    = dw_q;
    perr_d  = perr_q;
    dval_d  = 1'b0;
    merr_d  = 1'b0;
    busy_d  = busy_q;
    bit_idx = int'(cnt_q) / SPB;
    phase   = int'(cnt_q) % SPB;
    bad     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sync_csw || sync_dw) begin
          type_d  = sync_csw ? SYNC_CSW : SYNC_DW;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (phase == PH_FIRST) begin
          if (lvl == LVL_IDLE) bad = 1'b1;
          else                 first_d = (lvl == LVL_HI);
        end else if (phase == PH_SECOND) begin
          if (lvl == LVL_IDLE || (lvl == LVL_HI) == first_q) bad = 1'b1;
          else if (bit_idx < WORD_BITS - 1) data_d = {data_q[14:0], first_q};
          else par_d = first_q;
        end
        if (bad) begin
          merr_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // Use the _d values: for small SPB the parity sample lands on the last count.
          dword_d = data_d;
          csw_d   = (type_q == SYNC_CSW);
          dw_d    = (type_q == SYNC_DW);
          perr_d  = ~(^{data_d, par_d});
          dval_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      first_q <= 1'b0;
      data_q  <= '0;
      par_q   <= 1'b0;
      type_q  <= 1'b0;
      dword_q <= '0;
      csw_q   <= 1'b0;
      dw_q    <= 1'b0;
      perr_q  <= 1'b0;
      dval_q  <= 1'b0;
      merr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      data_q  <= data_d;
      par_q   <= par_d;
      type_q  <= type_d;
      dword_q <= dword_d;
      csw_q   <= csw_d;
      dw_q    <= dw_d;
      perr_q  <= perr_d;
      dval_q  <= dval_d;
      merr_q  <= merr_d;
      busy_q  <= busy_d;
    end
  end

  assign rx_dword = dword_q;
  assign rx_csw   = csw_q;
  assign rx_dw    = dw_q;
  assign rx_dval  = dval_q;
  assign rx_perr  = perr_q;
  assign rx_merr  = merr_q;
  assign rx_busy  = busy_q;

endmodule

// File: tb/tb_rx_decoder_1553.sv
// tb/tb_rx_decoder_1553.sv - self-checking bench for rx_decoder_1553
`timescale 1ns/1ps
module tb_rx_decoder_1553;

  localparam int SPB      = 8;
  localparam int SYNC_TOL = 1;
  localparam int WORD_CYC = 20 * SPB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_p = 1'b0;
  logic        rx_n = 1'b0;
  logic [15:0] rx_dword;
  logic        rx_csw, rx_dw, rx_dval, rx_perr, rx_merr, rx_busy;

  rx_decoder_1553 #(.SPB(SPB), .SYNC_TOL(SYNC_TOL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_p     (rx_p),
    .rx_n     (rx_n),
    .rx_dword (rx_dword),
    .rx_csw   (rx_csw),
    .rx_dw    (rx_dw),
    .rx_dval  (rx_dval),
    .rx_perr  (rx_perr),
    .rx_merr  (rx_merr),
    .rx_busy  (rx_busy)
  );

  always #62.5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] dword;
    logic        csw;
    logic        dw;
    logic        perr;
  } dval_rec_t;

  dval_rec_t dq[$];
  int        busy_runs[$];
  int        busy_run = 0;
  int        merr_cnt = 0;
  int        overlap_cnt = 0;
  int        cyc = 0;
  int        checks = 0;
  int        errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_dval) dq.push_back('{cyc, rx_dword, rx_csw, rx_dw, rx_perr});
    if (rx_merr) merr_cnt++;
    if (rx_dval && rx_merr) overlap_cnt++;
    if (rx_busy) busy_run++;
    else if (busy_run != 0) begin
      busy_runs.push_back(busy_run);
      busy_run = 0;
    end
  end

  function automatic void clear_mon();
    dq.delete();
    busy_runs.delete();
    busy_run = 0;
    merr_cnt = 0;
  endfunction

  // parity bit giving an odd total number of ones
  function automatic logic odd_par(input logic [15:0] d);
    return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  function automatic logic [18:0] expect_rec(input logic c, input logic [15:0] d, input logic p);
    logic perr;
    perr = (($countones(d) + int'(p)) % 2 == 0);
    return {d, c, ~c, perr};
  endfunction

  task automatic drive(input logic p, input logic n, input real t);
    rx_p = p;
    rx_n = n;
    #(t);
  endtask

  task automatic go_idle();
    rx_p = 1'b0;
    rx_n = 1'b0;
  endtask

  task automatic align();
    @(posedge clk);
    #17.153;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Encoder: 3 us sync, then 16 data bits MSB first and parity.
  // bad_bit: that bit's second half repeats the first; gap_bit: 3 us idle before that bit.
  task automatic send_word(input logic csw, input logic [15:0] d, input logic par,
                           input int bad_bit, input int gap_bit);
    logic [16:0] bits;
    logic        b;
    bits = {d, par};
    if (csw) begin
      drive(1'b1, 1'b0, 1500.0);
      drive(1'b0, 1'b1, 1500.0);
    end else begin
      drive(1'b0, 1'b1, 1500.0);
      drive(1'b1, 1'b0, 1500.0);
    end
    for (int k = 0; k < 17; k++) begin
      b = bits[16-k];
      if (k == gap_bit) drive(1'b0, 1'b0, 3000.0);
      drive(b, ~b, 500.0);
      if (k == bad_bit) drive(b, ~b, 500.0);
      else              drive(~b, b, 500.0);
    end
  endtask

  task automatic test_reset();
    wait_cycles(3);
    #1;
    checks++;
    if ({rx_dword, rx_csw, rx_dw, rx_dval, rx_perr, rx_merr, rx_busy} !== 22'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0",
               {rx_dword, rx_csw, rx_dw, rx_dval, rx_perr, rx_merr, rx_busy});
    end
    rst_n = 1'b1;
    wait_cycles(4);
  endtask

  task automatic test_csw_5555();
    logic [18:0] exp;
    clear_mon();
    align();
    send_word(1'b1, 16'h5555, odd_par(16'h5555), -1, -1);
    go_idle();
    wait_cycles(24);
    exp = expect_rec(1'b1, 16'h5555, odd_par(16'h5555));
    checks++;
    if (dq.size() !== 1) begin
      errors++;
      $display("FAIL csw5555_dval_count got %0d want 1", dq.size());
    end else begin
      checks++;
      if ({dq[0].dword, dq[0].csw, dq[0].dw, dq[0].perr} !== exp) begin
        errors++;
        $display("FAIL csw5555_word got %h want %h",
                 {dq[0].dword, dq[0].csw, dq[0].dw, dq[0].perr}, exp);
      end
    end
    checks++;
    if (busy_runs.size() !== 1 || busy_runs[0] !== 17 * SPB + 1) begin
      errors++;
      $display("FAIL csw5555_busy_len got %0d runs first %0d want 1 run of %0d",
               busy_runs.size(), (busy_runs.size() > 0) ? busy_runs[0] : -1, 17 * SPB + 1);
    end
    checks++;
    if (merr_cnt !== 0) begin
      errors++;
      $display("FAIL csw5555_merr got %0d want 0", merr_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [18:0] exp0, exp1;
    clear_mon();
    align();
    send_word(1'b0, 16'hABCD, odd_par(16'hABCD), -1, -1);
    send_word(1'b0, 16'h1234, odd_par(16'h1234), -1, -1);
    go_idle();
    wait_cycles(24);
    exp0 = expect_rec(1'b0, 16'hABCD, odd_par(16'hABCD));
    exp1 = expect_rec(1'b0, 16'h1234, odd_par(16'h1234));
    checks++;
    if (dq.size() !== 2) begin
      errors++;
      $display("FAIL b2b_dval_count got %0d want 2", dq.size());
    end else begin
      checks++;
      if ({dq[0].dword, dq[0].csw, dq[0].dw, dq[0].perr} !== exp0) begin
        errors++;
        $display("FAIL b2b_word0 got %h want %h",
                 {dq[0].dword, dq[0].csw, dq[0].dw, dq[0].perr}, exp0);
      end
      checks++;
      if ({dq[1].dword, dq[1].csw, dq[1].dw, dq[1].perr} !== exp1) begin
        errors++;
        $display("FAIL b2b_word1 got %h want %h",
                 {dq[1].dword, dq[1].csw, dq[1].dw, dq[1].perr}, exp1);
      end
      checks++;
      if (dq[1].cyc - dq[0].cyc !== WORD_CYC) begin
        errors++;
        $display("FAIL b2b_spacing got %0d want %0d", dq[1].cyc - dq[0].cyc, WORD_CYC);
      end
    end
  endtask

  task automatic test_parity_error();
    logic [18:0] exp;
    clear_mon();
    align();
    send_word(1'b1, 16'hFFFF, ~odd_par(16'hFFFF), -1, -1);
    go_idle();
    wait_cycles(24);
    exp = {16'hFFFF, 1'b1, 1'b0, 1'b1};
    checks++;
    if (dq.size() !== 1) begin
      errors++;
      $display("FAIL perr_dval_count got %0d want 1", dq.size());
    end else begin
      checks++;
      if ({dq[0].dword, dq[0].csw, dq[0].dw, dq[0].perr} !== exp) begin
        errors++;
        $display("FAIL perr_word got %h want %h",
                 {dq[0].dword, dq[0].csw, dq[0].dw, dq[0].perr}, exp);
      end
    end
  endtask

  task automatic test_manchester_error();
    clear_mon();
    align();
    send_word(1'b1, 16'h5678, odd_par(16'h5678), 5, -1);
    go_idle();
    wait_cycles(24);
    checks++;
    if (merr_cnt !== 1 || dq.size() !== 0) begin
      errors++;
      $display("FAIL merr_bit5 got merr %0d dval %0d want merr 1 dval 0", merr_cnt, dq.size());
    end
    checks++;
    if ({rx_dword, rx_perr, rx_busy} !== {16'hFFFF, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL merr_hold got %h want %h", {rx_dword, rx_perr, rx_busy},
               {16'hFFFF, 1'b1, 1'b0});
    end
  endtask

  task automatic test_idle_gap();
    logic [18:0] exp;
    clear_mon();
    align();
    send_word(1'b1, 16'hAAAA, odd_par(16'hAAAA), -1, 8);
    go_idle();
    wait_cycles(24);
    checks++;
    if (merr_cnt !== 1 || dq.size() !== 0 || rx_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_gap got merr %0d dval %0d busy %b want 1 0 0",
               merr_cnt, dq.size(), rx_busy);
    end
    clear_mon();
    align();
    send_word(1'b0, 16'h0001, odd_par(16'h0001), -1, -1);
    go_idle();
    wait_cycles(24);
    exp = expect_rec(1'b0, 16'h0001, odd_par(16'h0001));
    checks++;
    if (dq.size() !== 1 || {dq[0].dword, dq[0].csw, dq[0].dw, dq[0].perr} !== exp) begin
      errors++;
      $display("FAIL after_gap_word got count %0d word %h want 1 %h", dq.size(),
               (dq.size() > 0) ? {dq[0].dword, dq[0].csw, dq[0].dw, dq[0].perr} : 19'h0, exp);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [18:0] exp;
    logic        busy_before;
    clear_mon();
    align();
    fork
      send_word(1'b1, 16'h3C3C, odd_par(16'h3C3C), -1, -1);
      begin
        wait_cycles(40);
        #1;
        busy_before = rx_busy;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy_before !== 1'b1) begin
          errors++;
          $display("FAIL midword_busy_before got %b want 1", busy_before);
        end
        checks++;
        if ({rx_dword, rx_csw, rx_dw, rx_dval, rx_perr, rx_merr, rx_busy} !== 22'h0) begin
          errors++;
          $display("FAIL midword_reset_outputs got %h want 0",
                   {rx_dword, rx_csw, rx_dw, rx_dval, rx_perr, rx_merr, rx_busy});
        end
        wait_cycles(3);
        #1 rst_n = 1'b1;
      end
    join
    go_idle();
    wait_cycles(24);
    checks++;
    if (dq.size() !== 0 || merr_cnt !== 0) begin
      errors++;
      $display("FAIL midword_no_output got dval %0d merr %0d want 0 0", dq.size(), merr_cnt);
    end
    clear_mon();
    align();
    send_word(1'b1, 16'hC0DE, odd_par(16'hC0DE), -1, -1);
    go_idle();
    wait_cycles(24);
    exp = expect_rec(1'b1, 16'hC0DE, odd_par(16'hC0DE));
    checks++;
    if (dq.size() !== 1 || {dq[0].dword, dq[0].csw, dq[0].dw, dq[0].perr} !== exp) begin
      errors++;
      $display("FAIL after_reset_word got count %0d word %h want 1 %h", dq.size(),
               (dq.size() > 0) ? {dq[0].dword, dq[0].csw, dq[0].dw, dq[0].perr} : 19'h0, exp);
    end
  endtask

  // Runs of at most 900 ns are too short to look like half of a sync.
  task automatic test_noise();
    int lv, prev;
    clear_mon();
    align();
    prev = 0;
    for (int s = 0; s < 40; s++) begin
      lv = int'($urandom_range(0, 3));
      if (lv == prev) lv = (lv + 1) % 4;
      prev = lv;
      drive(lv[1], lv[0], real'($urandom_range(50, 900)));
    end
    go_idle();
    wait_cycles(40);
    checks++;
    if (dq.size() !== 0 || merr_cnt !== 0 || busy_runs.size() !== 0 || busy_run !== 0) begin
      errors++;
      $display("FAIL noise got dval %0d merr %0d busy_runs %0d want all 0",
               dq.size(), merr_cnt, busy_runs.size() + busy_run);
    end
  endtask

  task automatic test_random();
    logic [18:0] exp_q[$];
    logic        c, p;
    logic [15:0] d;
    int          gap;
    clear_mon();
    align();
    for (int w = 0; w < 10; w++) begin
      c   = 1'($urandom);
      d   = 16'($urandom);
      p   = ($urandom_range(0, 3) == 0) ? ~odd_par(d) : odd_par(d);
      gap = int'($urandom_range(0, 6));
      exp_q.push_back(expect_rec(c, d, p));
      send_word(c, d, p, -1, -1);
      if (gap != 0) begin
        go_idle();
        #(real'(gap) * 500.0);
      end
    end
    go_idle();
    wait_cycles(24);
    checks++;
    if (dq.size() !== exp_q.size() || merr_cnt !== 0) begin
      errors++;
      $display("FAIL random_count got dval %0d merr %0d want %0d 0",
               dq.size(), merr_cnt, exp_q.size());
    end
    for (int i = 0; i < dq.size() && i < exp_q.size(); i++) begin
      checks++;
      if ({dq[i].dword, dq[i].csw, dq[i].dw, dq[i].perr} !== exp_q[i]) begin
        errors++;
        $display("FAIL random_word%0d got %h want %h", i,
                 {dq[i].dword, dq[i].csw, dq[i].dw, dq[i].perr}, exp_q[i]);
      end
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (overlap_cnt !== 0) begin
      errors++;
      $display("FAIL dval_merr_overlap got %0d want 0", overlap_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_csw_5555();
    test_back_to_back();
    test_parity_error();
    test_manchester_error();
    test_idle_gap();
    test_reset_mid_word();
    test_noise();
    test_random();
    test_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_decoder_1553.md
Name: rx_decoder_1553

Overview:
- MIL-STD-1553 word receiver for one bus channel: the receive end of the Manchester-II serial format produced by the project's 1553 word encoder.
- Takes the differential transceiver outputs (rx_p/rx_n) and synchronises them to clk.
- Detects the 3-bit-time sync, Manchester-decodes 16 data bits plus odd parity, and presents one decoded word per 20 µs word time to the protocol logic in top_1553 (BC or RT side).

Parameters:
- SPB, 8, clk samples per 1 µs bit time; must be a multiple of 4. Default assumes an 8 MHz clk.
- SYNC_TOL, 1, samples ignored at each sync edge when matching the sync pattern.

Ports:
- clk  in  1  sample clock, SPB MHz
- rst_n  in  1  asynchronous active-low reset
- rx_p  in  1  bus positive receiver output, asynchronous
- rx_n  in  1  bus negative receiver output, asynchronous
- rx_dword  out  16  decoded data word, MSB = first bit received
- rx_csw  out  1  word had command/status sync (high then low)
- rx_dw  out  1  word had data sync (low then high)
- rx_dval  out  1  one-cycle pulse: rx_dword/rx_csw/rx_dw/rx_perr are valid
- rx_perr  out  1  odd-parity failure; qualified by rx_dval
- rx_merr  out  1  one-cycle pulse: Manchester or idle-line error, word discarded
- rx_busy  out  1  high from sync detect until word completion or abort

Behaviour:
- Reset: all outputs 0; FSM to IDLE; synchroniser flops 0; sync shift register 0.
- Input conditioning:
  - rx_p and rx_n each pass through a 2-flop synchroniser.
  - Line level per sample: HI = p&~n, LO = ~p&n, IDLE = p==n.
- Sync detection:
  - A 3*SPB-sample shift register holds the line levels and shifts every clk.
  - CSW sync = first 1.5*SPB samples HI, next 1.5*SPB samples LO, excluding SYNC_TOL samples on each side of each edge.
  - DW sync is the inverse of CSW sync.
  - Detection is evaluated only in IDLE.
- FSM states:
  - IDLE: on sync match, latch the sync type, clear the bit counter, assert rx_busy, go to DATA.
  - DATA:
    - Sample counter runs 0..(17*SPB-1).
    - For bit k = 0..16, half h = 0..1, sample the line level at counter = k*SPB + h*SPB/2 + SPB/4.
    - Bit value: HI then LO = 1; LO then HI = 0.
    - Equal halves, or any IDLE sample, is a Manchester error: pulse rx_merr the next cycle, drop rx_busy, go to IDLE, leave rx_dword unchanged.
    - Bits 0..15 shift MSB-first into the data register; bit 16 is parity.
  - DONE (1 cycle):
    - rx_dword, rx_csw, rx_dw and rx_perr update.
    - rx_perr = ~(^{data, parity}); an odd count of ones is correct.
    - rx_dval pulses, rx_busy drops, go to IDLE.
- Latency: rx_dval is asserted 17*SPB+1 cycles after the sync-detect cycle, plus the 2-cycle synchroniser.
- Output holding: rx_dword/rx_csw/rx_dw/rx_perr hold until the next DONE. rx_dval and rx_merr are never high together.
- Back-to-back words: the shift register runs continuously, so a sync immediately following parity (zero gap) is detected.
- Line noise: noise or an isolated pulse with no valid sync leaves the FSM in IDLE with no outputs.
- Reset mid-word: immediate return to IDLE with outputs cleared; no rx_dval.
- Width rules: sample counter width is clog2(17*SPB); the bit index is derived from the counter, with no separate counter.

Decomposition:
- Shared package pkg_1553:
  - line-level encoding constants (LVL_HI, LVL_LO, LVL_IDLE)
  - FSM state enum
  - sync-type constants
  - the word-length constant 17 (data plus parity bits)
- One natural sub-module: sync_detect_1553. It contains the synchroniser, line-level mapping, shift register and pattern match, and outputs a one-cycle sync_csw/sync_dw pulse.
- The decode FSM stays in the top.

Test Plan:
- Encoder drives CSW 16'h5555 with correct parity into rx_p/rx_n (17.153 ns delay) -> one rx_dval; rx_dword=16'h5555, rx_csw=1, rx_dw=0, rx_perr=0; rx_busy high for 17*SPB+1 cycles.
- DW 16'hABCD followed back-to-back with zero gap by DW 16'h1234 -> two rx_dval pulses exactly 20*SPB cycles apart; rx_dw=1 for both; values match.
- Word 16'hFFFF with parity bit forced wrong -> rx_dval with rx_dword=16'hFFFF and rx_perr=1.
- CSW 16'h5678 with bit 5's second half inverted (no mid-bit transition) -> rx_merr pulse; no rx_dval; rx_dword retains the previous value.
- Both rx_p and rx_n driven 0 for 3 µs midway through word 16'hAAAA -> rx_merr, rx_busy=0; a following valid DW 16'h0001 decodes correctly.
- rst_n asserted 40 cycles into a word -> all outputs 0 immediately; after release, the next full word decodes normally.
